clk_period_monitor: RTL and testbench

//  Synthesizable clock-period checker. Measures the period of a monitored clock (mon_clk) in cycles of a faster

---
 rtl/clk_period_monitor_if.sv | 52 +++++
 rtl/clk_period_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_clk_period_monitor.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_period_monitor_if.sv
// Purpose : bundles the control inputs and measurement results of clk_period_monitor.
// Latency : none; wires only.
// Backpress: none; results are unconditional pulses and levels.
//
// Signals (slave = monitor side, master = controlling side):
//   en, mon_clk, exp_period, tol, err_clr  master -> slave
//   period, period_vld, too_short,
//   too_long, stuck, err_cnt               slave -> master
//   period_min, period_max                 slave -> master, only with CLK_MON_MINMAX_EN
// Optional feature macro: CLK_MON_MINMAX_EN
interface clk_period_monitor_if #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
);
  logic             en;
  logic             mon_clk;
  logic [CNT_W-1:0] exp_period;
  logic [CNT_W-1:0] tol;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             too_short;
  logic             too_long;
  logic             stuck;
  logic [ERR_W-1:0] err_cnt;
`ifdef CLK_MON_MINMAX_EN
  logic [CNT_W-1:0] period_min;
  logic [CNT_W-1:0] period_max;

  modport master (
    output en, mon_clk, exp_period, tol, err_clr,
    input  period, period_vld, too_short, too_long, stuck, err_cnt,
    input  period_min, period_max
  );

  modport slave (
    input  en, mon_clk, exp_period, tol, err_clr,
    output period, period_vld, too_short, too_long, stuck, err_cnt,
    output period_min, period_max
  );
`else
  modport master (
    output en, mon_clk, exp_period, tol, err_clr,
    input  period, period_vld, too_short, too_long, stuck, err_cnt
  );

  modport slave (
    input  en, mon_clk, exp_period, tol, err_clr,
    output period, period_vld, too_short, too_long, stuck, err_cnt
  );
`endif
endinterface

// File: rtl/clk_period_monitor.sv
// Purpose : measures mon_clk period in clk cycles, checks it against exp_period +/- tol, flags errors.
// Latency : mon_clk rise -> period/period_vld/flags registered 3 clk later (2-flop sync + edge detect).
// Backpress: none; period_vld is a one-cycle pulse and the consumer must take it when it appears.
//
// Ports:
//   clk    reference clock (rising edge)
//   rst_n  asynchronous active-low reset
//   bus    clk_period_monitor_if.slave: en, mon_clk, exp_period, tol, err_clr in;
//          period, period_vld, too_short, too_long, stuck, err_cnt out
//          (+ period_min/period_max when CLK_MON_MINMAX_EN is defined)
// Optional feature macro: CLK_MON_MINMAX_EN (min/max tracking of published periods)
module clk_period_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024,
  parameter int ERR_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  clk_period_monitor_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_vld_q, period_vld_d;
  logic             too_short_q, too_short_d;
  logic             too_long_q, too_long_d;
  logic             stuck_q, stuck_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             mon_edge;
  logic             publish;
  logic             stuck_evt;
  logic [CNT_W:0]   lo_bound;
  logic [CNT_W:0]   hi_bound;
  logic             is_short;
  logic             is_long;
  logic             err_base_short;
  logic             err_base_long;
  logic             err_base_stuck;
  logic [ERR_W-1:0] err_base_cnt;

`ifdef CLK_MON_MINMAX_EN
  logic [CNT_W-1:0] period_min_q, period_min_d;
  logic [CNT_W-1:0] period_max_q, period_max_d;
  logic [CNT_W-1:0] min_base;
  logic [CNT_W-1:0] max_base;
`endif

  // Synchronizer and edge-detect stage.
  always_comb begin
    s1_d     = bus.mon_clk;
    s2_d     = s1_q;
    s3_d     = s2_q;
    mon_edge = s2_q & ~s3_q;
  end

  // Measurement FSM and period counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    publish   = 1'b0;
    stuck_evt = 1'b0;
    if (!bus.en) begin
      // Partial count is thrown away; the next edge after re-enable only starts a measurement.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mon_edge) begin
            state_d = MEAS;
            cnt_d   = CNT_W'(1);
          end
        end
        MEAS: begin
          // An edge landing on the timeout cycle is still a valid period.
          if (mon_edge) begin
            publish = 1'b1;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == TIMEOUT_C) begin
            state_d   = STUCK;
            stuck_evt = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STUCK: begin
          // The gap before this edge is meaningless, so no publish.
          if (mon_edge) begin
            state_d = MEAS;
            cnt_d   = CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Tolerance window, one bit wider so exp+tol cannot overflow and exp-tol clamps at zero.
  always_comb begin
    hi_bound = {1'b0, bus.exp_period} + {1'b0, bus.tol};
    if (bus.exp_period >= bus.tol) begin
      lo_bound = {1'b0, bus.exp_period} - {1'b0, bus.tol};
    end else begin
      lo_bound = '0;
    end
    is_short = publish && ({1'b0, cnt_q} < lo_bound);
    is_long  = publish && ({1'b0, cnt_q} > hi_bound);
  end

  // Results. err_clr acts first so an error in the same cycle survives the clear.
  always_comb begin
    period_d     = publish ? cnt_q : period_q;
    period_vld_d = publish;

    err_base_short = bus.err_clr ? 1'b0 : too_short_q;
    err_base_long  = bus.err_clr ? 1'b0 : too_long_q;
    err_base_stuck = bus.err_clr ? 1'b0 : stuck_q;
    err_base_cnt   = bus.err_clr ? '0   : err_cnt_q;

    too_short_d = err_base_short | is_short;
    too_long_d  = err_base_long  | is_long;
    stuck_d     = err_base_stuck | stuck_evt;

    if ((is_short || is_long || stuck_evt) && (err_base_cnt != '1)) begin
      err_cnt_d = err_base_cnt + ERR_W'(1);
    end else begin
      err_cnt_d = err_base_cnt;
    end
  end

`ifdef CLK_MON_MINMAX_EN
  always_comb begin
    min_base     = bus.err_clr ? '1 : period_min_q;
    max_base     = bus.err_clr ? '0 : period_max_q;
    period_min_d = (publish && (cnt_q < min_base)) ? cnt_q : min_base;
    period_max_d = (publish && (cnt_q > max_base)) ? cnt_q : max_base;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      too_short_q  <= 1'b0;
      too_long_q   <= 1'b0;
      stuck_q      <= 1'b0;
      err_cnt_q    <= '0;
`ifdef CLK_MON_MINMAX_EN
      period_min_q <= '1;
      period_max_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      too_short_q  <= too_short_d;
      too_long_q   <= too_long_d;
      stuck_q      <= stuck_d;
      err_cnt_q    <= err_cnt_d;
`ifdef CLK_MON_MINMAX_EN
      period_min_q <= period_min_d;
      period_max_q <= period_max_d;
`endif
    end
  end

  assign bus.period     = period_q;
  assign bus.period_vld = period_vld_q;
  assign bus.too_short  = too_short_q;
  assign bus.too_long   = too_long_q;
  assign bus.stuck      = stuck_q;
  assign bus.err_cnt    = err_cnt_q;
`ifdef CLK_MON_MINMAX_EN
  assign bus.period_min = period_min_q;
  assign bus.period_max = period_max_q;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Purpose : self-checking bench for clk_period_monitor against a period-level reference model.
// Latency : model works on mon_clk rise-to-rise gaps; results are compared once the pipeline has settled.
// Backpress: none.
module tb_clk_period_monitor;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int ERR_W   = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
  // Clocks from a mon_clk rise until the monitor sees it (sync + edge detect).
  localparam int LAT     = 3;

  logic clk;
  logic rst_n;

  clk_period_monitor_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  clk_period_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = idle, 1 = measuring, 2 = stuck.
  int m_state = 0;
  int m_gap   = 0;
  int m_period = 0;
  int m_err    = 0;
  bit m_short  = 1'b0;
  bit m_long   = 1'b0;
  bit m_stuck  = 1'b0;
  int m_min    = 65535;
  int m_max    = 0;
  int exp_v    = 10;
  int tol_v    = 1;
  int exp_q[$];
  int pub_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.period_vld === 1'b1) pub_q.push_back(int'(bus.period));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void m_error();
    if (m_err < ERR_MAX) m_err++;
  endfunction

  function automatic void m_clear();
    m_short = 1'b0;
    m_long  = 1'b0;
    m_stuck = 1'b0;
    m_err   = 0;
    m_min   = 65535;
    m_max   = 0;
  endfunction

  function automatic void m_go_stuck();
    m_stuck = 1'b1;
    m_error();
    m_state = 2;
  endfunction

  function automatic void m_publish(input int p);
    int lo;
    int hi;
    lo = exp_v - tol_v;
    if (lo < 0) lo = 0;
    hi = exp_v + tol_v;
    m_period = p;
    exp_q.push_back(p);
    if (p < lo) begin
      m_short = 1'b1;
      m_error();
    end else if (p > hi) begin
      m_long = 1'b1;
      m_error();
    end
    if (p < m_min) m_min = p;
    if (p > m_max) m_max = p;
  endfunction

  // A mon_clk rise, m_gap clocks after the previous one.
  function automatic void m_rise();
    if (bus.en === 1'b1) begin
      case (m_state)
        0: m_state = 1;
        1: begin
          if (m_gap > TIMEOUT) begin
            m_go_stuck();
            m_state = 1;
          end else begin
            m_publish(m_gap);
          end
        end
        default: m_state = 1;
      endcase
    end
    m_gap = 0;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      m_gap++;
      if (m_state == 1 && m_gap >= TIMEOUT + LAT) m_go_stuck();
    end
  endtask

  task automatic mon_edge(input int g);
    int h;
    h = g / 2;
    bus.mon_clk = 1'b1;
    m_rise();
    step(h);
    bus.mon_clk = 1'b0;
    step(g - h);
  endtask

  // Rise whose detection cycle coincides with an err_clr pulse.
  task automatic edge_with_clr(input int g);
    int h;
    h = g / 2;
    bus.mon_clk = 1'b1;
    m_clear();
    m_rise();
    step(LAT - 1);
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    step(h - LAT);
    bus.mon_clk = 1'b0;
    step(g - h);
  endtask

  task automatic clr_pulse();
    bus.err_clr = 1'b1;
    m_clear();
    step(1);
    bus.err_clr = 1'b0;
  endtask

  task automatic set_cfg(input int e, input int t);
    exp_v = e;
    tol_v = t;
    bus.exp_period = CNT_W'(e);
    bus.tol        = CNT_W'(t);
  endtask

  task automatic set_en(input logic v);
    bus.en = v;
    if (!v) m_state = 0;
    step(3);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":npub"}, 32'(pub_q.size()), 32'(exp_q.size()));
    while (pub_q.size() > 0 && exp_q.size() > 0)
      chk({tag, ":pub"}, 32'(pub_q.pop_front()), 32'(exp_q.pop_front()));
    pub_q.delete();
    exp_q.delete();
    chk({tag, ":period"},    32'(bus.period),    32'(m_period));
    chk({tag, ":too_short"}, 32'(bus.too_short), 32'(m_short));
    chk({tag, ":too_long"},  32'(bus.too_long),  32'(m_long));
    chk({tag, ":stuck"},     32'(bus.stuck),     32'(m_stuck));
    chk({tag, ":err_cnt"},   32'(bus.err_cnt),   32'(m_err));
`ifdef CLK_MON_MINMAX_EN
    chk({tag, ":period_min"}, 32'(bus.period_min), 32'(m_min));
    chk({tag, ":period_max"}, 32'(bus.period_max), 32'(m_max));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ":period"},     32'(bus.period),     32'd0);
    chk({tag, ":period_vld"}, 32'(bus.period_vld), 32'd0);
    chk({tag, ":too_short"},  32'(bus.too_short),  32'd0);
    chk({tag, ":too_long"},   32'(bus.too_long),   32'd0);
    chk({tag, ":stuck"},      32'(bus.stuck),      32'd0);
    chk({tag, ":err_cnt"},    32'(bus.err_cnt),    32'd0);
`ifdef CLK_MON_MINMAX_EN
    chk({tag, ":period_min"}, 32'(bus.period_min), 32'hFFFF);
    chk({tag, ":period_max"}, 32'(bus.period_max), 32'd0);
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.mon_clk = 1'b0;
    bus.err_clr = 1'b0;
    set_cfg(10, 1);

    // Reset state.
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    set_en(1'b1);

    // Nominal 10-clk period inside tolerance.
    repeat (6) mon_edge(10);
    check_state("nominal");

    // Short periods; error count climbs then saturates.
    set_cfg(10, 2);
    repeat (5) mon_edge(7);
    check_state("short");
    clr_pulse();
    check_state("clr1");

    // Long periods, then clear.
    repeat (2) mon_edge(14);
    check_state("long");
    clr_pulse();
    check_state("clr2");

    // Gap exactly TIMEOUT: edge wins over timeout.
    mon_edge(64);
    mon_edge(10);
    check_state("edge_wins");

    // Stuck: exact timing, then one silent edge, then a normal publish.
    clr_pulse();
    bus.mon_clk = 1'b1;
    m_rise();
    step(2);
    bus.mon_clk = 1'b0;
    step(TIMEOUT + LAT - 3);
    chk("stuck_before", 32'(bus.stuck), 32'(m_stuck));
    step(1);
    chk("stuck_at", 32'(bus.stuck), 32'(m_stuck));
    mon_edge(10);
    mon_edge(10);
    check_state("after_stuck");

    // Lower bound clamps at zero.
    set_cfg(3, 5);
    mon_edge(7);
    clr_pulse();
    repeat (3) mon_edge(2);
    mon_edge(8);
    check_state("lo_clamp");

    // Saturation of err_cnt.
    set_cfg(20, 1);
    repeat (6) mon_edge(5);
    check_state("saturate");

    // err_clr in the same cycle as a new error.
    edge_with_clr(8);
    check_state("clr_vs_err");

    // en dropped mid-period: partial count discarded, first edge after re-enable silent.
    set_cfg(10, 2);
    clr_pulse();
    mon_edge(10);
    mon_edge(3);
    set_en(1'b0);
    step(5);
    set_en(1'b1);
    mon_edge(10);
    mon_edge(10);
    mon_edge(10);
    check_state("en_drop");

    // Min/max tracking after a clear.
    clr_pulse();
    mon_edge(9);
    mon_edge(12);
    mon_edge(10);
    mon_edge(10);
    check_state("minmax");

    // Randomized windows and periods.
    for (int r = 0; r < 4; r++) begin
      set_cfg(int'($urandom_range(30, 5)), int'($urandom_range(6, 0)));
      for (int k = 0; k < 8; k++) mon_edge(int'($urandom_range(40, 4)));
      check_state($sformatf("rand%0d", r));
      if ($urandom_range(1, 0) == 1) begin
        clr_pulse();
        check_state($sformatf("rand_clr%0d", r));
      end
    end

    // Asynchronous reset mid-run.
    repeat (2) mon_edge(10);
    check_state("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    m_state  = 0;
    m_period = 0;
    m_gap    = 0;
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    repeat (3) mon_edge(10);
    check_state("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
